// File: rtl/ws2811_serializer_if.sv
// Signal bundle between the WS2811 serializer, the LED controller and the frame sequencer.
// The master modport is the serializer's view; the slave modport is the surrounding system's view.
interface ws2811_serializer_if;
  logic       start;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [7:0] ledindex;
  logic       dout;
  logic       busy;
  logic       frame_done;

  modport master (
    input  start, red, green, blue,
    output ledindex, dout, busy, frame_done
  );

  modport slave (
    output start, red, green, blue,
    input  ledindex, dout, busy, frame_done
  );
endinterface

// File: rtl/ws2811_serializer.sv
// WS2811 single-wire serializer: walks ledindex through the strip and emits 24-bit pulse-width coded words.
// Optional macro WS2811_GRB_ORDER_EN loads words as G,R,B instead of the default R,G,B.
module ws2811_serializer #(
  parameter int NUM_LEDS     = 50,
  parameter int BIT_CYCLES   = 63,
  parameter int T0H_CYCLES   = 13,
  parameter int T1H_CYCLES   = 30,
  parameter int RESET_CYCLES = 2500
) (
  input  logic                 clk,
  input  logic                 reset,
  ws2811_serializer_if.master  bus
);

  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 2;
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);
  localparam logic [CW-1:0] PRIME_LAST = CW'(1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [7:0]    LED_LAST = 8'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SHIFT,
    LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0]    bit_q, bit_d;
  logic [7:0]    led_q, led_d;
  logic [7:0]    idx_q, idx_d;
  logic [23:0]   sh_q, sh_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [23:0]   load_word;
  logic [CW-1:0] cyc_inc;
  logic [CW-1:0] high_len;
  logic [7:0]    led_next;

`ifdef WS2811_GRB_ORDER_EN
  assign load_word = {bus.green, bus.red, bus.blue};
`else
  assign load_word = {bus.red, bus.green, bus.blue};
`endif

  assign cyc_inc  = cyc_q + CW'(1);
  assign high_len = sh_q[23] ? T1H : T0H;
  assign led_next = led_q + 8'd1;

  // dout_d always describes the cycle about to start, so the line itself stays a bare flop.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    led_d   = led_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    rcnt_d  = rcnt_q;
    dout_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = PRIME;
          busy_d  = 1'b1;
          cyc_d   = '0;
          idx_d   = 8'd0;
        end
      end

      PRIME: begin
        if (cyc_q == PRIME_LAST) begin
          state_d = SHIFT;
          cyc_d   = '0;
          bit_d   = 5'd0;
          led_d   = 8'd0;
          sh_d    = load_word;
          idx_d   = (LED_LAST == 8'd0) ? 8'd0 : 8'd1;
          dout_d  = 1'b1;
        end else begin
          cyc_d = cyc_inc;
        end
      end

      SHIFT: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_q == 5'd23) begin
            if (led_q == LED_LAST) begin
              state_d = LATCH;
              rcnt_d  = '0;
            end else begin
              // New LED starts here: its data was prefetched, and the next index goes out now.
              led_d  = led_next;
              bit_d  = 5'd0;
              sh_d   = load_word;
              idx_d  = (led_next == LED_LAST) ? 8'd0 : led_q + 8'd2;
              dout_d = 1'b1;
            end
          end else begin
            bit_d  = bit_q + 5'd1;
            sh_d   = {sh_q[22:0], 1'b0};
            dout_d = 1'b1;
          end
        end else begin
          cyc_d  = cyc_inc;
          dout_d = (cyc_inc < high_len);
        end
      end

      LATCH: begin
        if (rcnt_q == RST_LAST) begin
          state_d = IDLE;
          rcnt_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= 5'd0;
      led_q   <= 8'd0;
      idx_q   <= 8'd0;
      sh_q    <= 24'd0;
      rcnt_q  <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      rcnt_q  <= rcnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ledindex   = idx_q;
  assign bus.dout       = dout_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_ws2811_serializer.sv
// Scoreboard bench for ws2811_serializer: a short 2-LED strip and a 256-LED strip side by side,
// each fed by a one-cycle-registered colour model; dout pulses are decoded and matched against queued bits.
module tb_ws2811_serializer;

  localparam int A_LEDS = 2;
  localparam int A_BC   = 10;
  localparam int A_T0   = 3;
  localparam int A_T1   = 7;
  localparam int A_RC   = 20;
  localparam int A_DONE = 3 + A_LEDS * 24 * A_BC + A_RC;

  localparam int B_LEDS = 256;
  localparam int B_BC   = 4;
  localparam int B_T0   = 1;
  localparam int B_T1   = 3;
  localparam int B_RC   = 20;
  localparam int B_DONE = 3 + B_LEDS * 24 * B_BC + B_RC;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ws2811_serializer_if busA ();
  ws2811_serializer_if busB ();

  ws2811_serializer #(
    .NUM_LEDS(A_LEDS), .BIT_CYCLES(A_BC), .T0H_CYCLES(A_T0),
    .T1H_CYCLES(A_T1), .RESET_CYCLES(A_RC)
  ) dutA (
    .clk(clk), .reset(reset), .bus(busA.master)
  );

  ws2811_serializer #(
    .NUM_LEDS(B_LEDS), .BIT_CYCLES(B_BC), .T0H_CYCLES(B_T0),
    .T1H_CYCLES(B_T1), .RESET_CYCLES(B_RC)
  ) dutB (
    .clk(clk), .reset(reset), .bus(busB.master)
  );

  // Colour model: the LED controller answers ledindex one clock later.
  logic [23:0] memA [256];
  logic [23:0] memB [256];

  always @(posedge clk) begin
    {busA.red, busA.green, busA.blue} <= memA[busA.ledindex];
    {busB.red, busB.green, busB.blue} <= memB[busB.ledindex];
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  bit qA[$];
  bit qB[$];

  function automatic logic [23:0] wireWord(input logic [23:0] rgb);
`ifdef WS2811_GRB_ORDER_EN
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
`else
    return rgb;
`endif
  endfunction

  task automatic pushFrameA();
    logic [23:0] w;
    for (int i = 0; i < A_LEDS; i++) begin
      w = wireWord(memA[i]);
      for (int b = 23; b >= 0; b--) qA.push_back(w[b]);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] led0, input logic [23:0] led1);
    memA[0] = led0;
    memA[1] = led1;
    pushFrameA();
  endtask

  // Decoder for strip A: rising edge opens a bit, falling edge classifies it by high time.
  bit   monA = 1'b1;
  logic prevA = 1'b0;
  logic prevDoneA = 1'b0;
  int   highA = 0, lastRiseA = -1000, frameRiseA = -1;
  int   doneCntA = 0, doneCycA = -1;
  int   gotA, expA;

  always @(negedge clk) begin
    if (!monA) begin
      prevA     = busA.dout;
      highA     = 0;
      lastRiseA = -1000;
    end else begin
      if (busA.dout && !prevA) begin
        if (cyc - lastRiseA < 2 * A_BC) checkOutput("A bit period", cyc - lastRiseA, A_BC);
        else frameRiseA = cyc;
        lastRiseA = cyc;
        highA = 1;
      end else if (busA.dout) begin
        highA++;
      end else if (prevA) begin
        if (qA.size() == 0) begin
          checkOutput("A extra bit", qA.size(), 1);
        end else begin
          expA = int'(qA.pop_front());
          gotA = (highA == A_T1) ? 1 : ((highA == A_T0) ? 0 : 2);
          checkOutput("A bit", gotA, expA);
        end
      end
      prevA = busA.dout;
    end
    if (busA.frame_done) begin
      doneCntA++;
      doneCycA = cyc;
      checkOutput("A done width", int'(prevDoneA), 0);
    end
    prevDoneA = busA.frame_done;
  end

  // Decoder for strip B, plus the ledindex walk 1..255,0.
  logic       prevB = 1'b0;
  logic       prevDoneB = 1'b0;
  logic [7:0] prevIdxB = 8'd0;
  int         highB = 0, lastRiseB = -1000;
  int         doneCntB = 0, doneCycB = -1, bitCntB = 0;
  int         idxChangesB = 0, expIdxB = 1;
  int         gotB, expB;

  always @(negedge clk) begin
    if (busB.dout && !prevB) begin
      if (cyc - lastRiseB < 2 * B_BC) checkOutput("B bit period", cyc - lastRiseB, B_BC);
      lastRiseB = cyc;
      highB = 1;
    end else if (busB.dout) begin
      highB++;
    end else if (prevB) begin
      bitCntB++;
      if (qB.size() == 0) begin
        checkOutput("B extra bit", qB.size(), 1);
      end else begin
        expB = int'(qB.pop_front());
        gotB = (highB == B_T1) ? 1 : ((highB == B_T0) ? 0 : 2);
        checkOutput("B bit", gotB, expB);
      end
    end
    prevB = busB.dout;
    if (busB.ledindex !== prevIdxB) begin
      idxChangesB++;
      checkOutput("B ledindex", int'(busB.ledindex), expIdxB);
      expIdxB = (expIdxB + 1) % 256;
    end
    prevIdxB = busB.ledindex;
    if (busB.frame_done) begin
      doneCntB++;
      doneCycB = cyc;
      checkOutput("B done width", int'(prevDoneB), 0);
    end
    prevDoneB = busB.frame_done;
  end

  task automatic runFrameA(input bit pulseBusy);
    int s, c, d0, span;
    d0   = doneCntA;
    span = pulseBusy ? 1100 : A_DONE + 2;
    @(negedge clk);
    checkOutput("A busy idle", int'(busA.busy), 0);
    busA.start = 1'b1;
    s = cyc;
    @(negedge clk);
    busA.start = 1'b0;
    c = cyc - s;
    while (c < span) begin
      case (c)
        1: begin
          checkOutput("A busy c1", int'(busA.busy), 1);
          checkOutput("A idx c1", int'(busA.ledindex), 0);
        end
        2: checkOutput("A idx c2", int'(busA.ledindex), 0);
        3: begin
          checkOutput("A idx c3", int'(busA.ledindex), 1);
          checkOutput("A dout c3", int'(busA.dout), 1);
        end
        100: if (pulseBusy) busA.start = 1'b1;
        101: busA.start = 1'b0;
        242: checkOutput("A idx c242", int'(busA.ledindex), 1);
        243: checkOutput("A idx c243", int'(busA.ledindex), 0);
        A_DONE - 1: begin
          checkOutput("A busy pre-done", int'(busA.busy), 1);
          checkOutput("A done pre", int'(busA.frame_done), 0);
        end
        A_DONE: begin
          checkOutput("A busy at done", int'(busA.busy), 0);
          checkOutput("A done pulse", int'(busA.frame_done), 1);
        end
        A_DONE + 1: checkOutput("A done post", int'(busA.frame_done), 0);
        default: ;
      endcase
      @(negedge clk);
      c = cyc - s;
    end
    checkOutput("A bits left", qA.size(), 0);
    checkOutput("A first rise", frameRiseA - s, 3);
    checkOutput("A done cycle", doneCycA - s, A_DONE);
    checkOutput("A done count", doneCntA - d0, 1);
  endtask

  initial begin
    int s, dc, d0, n;
    bit seen;
    logic [23:0] w;

    for (int i = 0; i < 256; i++) begin
      memA[i] = 24'd0;
      memB[i] = 24'd0;
    end
    reset = 1'b1;
    busA.start = 1'b0;
    busB.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst dout", int'(busA.dout), 0);
    checkOutput("rst busy", int'(busA.busy), 0);
    checkOutput("rst ledindex", int'(busA.ledindex), 0);
    checkOutput("rst done", int'(busA.frame_done), 0);
    // start together with reset must not launch a frame
    busA.start = 1'b1;
    @(negedge clk);
    checkOutput("rst+start busy", int'(busA.busy), 0);
    busA.start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single frame");
    applyStimulus(24'hFF00AA, 24'h018000);
    runFrameA(1'b0);

    $display("[TB] start while busy");
    applyStimulus(24'hFF00AA, 24'h018000);
    runFrameA(1'b1);

    $display("[TB] byte order");
    applyStimulus(24'h123456, 24'hA55AC3);
    runFrameA(1'b0);

    $display("[TB] start held high");
    pushFrameA();
    pushFrameA();
    d0 = doneCntA;
    @(negedge clk);
    busA.start = 1'b1;
    seen = 1'b0;
    dc = 0;
    n = 0;
    while (!seen && n < A_DONE + 20) begin
      @(negedge clk);
      n++;
      if (busA.frame_done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    checkOutput("A held first done", int'(seen), 1);
    repeat (10) @(negedge clk);
    busA.start = 1'b0;
    checkOutput("A held restart", frameRiseA - dc, 3);
    n = 0;
    while (doneCntA - d0 < 2 && n < A_DONE + 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("A held done count", doneCntA - d0, 2);
    checkOutput("A held second done", doneCycA - dc, A_DONE);
    checkOutput("A held bits left", qA.size(), 0);
    repeat (5) @(negedge clk);

    $display("[TB] mid-frame reset");
    monA = 1'b0;
    memA[0] = 24'hFF00AA;
    memA[1] = 24'h018000;
    @(negedge clk);
    busA.start = 1'b1;
    s = cyc;
    @(negedge clk);
    busA.start = 1'b0;
    while (cyc - s < 5) @(negedge clk);
    checkOutput("A dout before reset", int'(busA.dout), 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("A reset dout", int'(busA.dout), 0);
    checkOutput("A reset busy", int'(busA.busy), 0);
    checkOutput("A reset ledindex", int'(busA.ledindex), 0);
    reset = 1'b0;
    qA.delete();
    repeat (3) @(negedge clk);
    monA = 1'b1;
    @(negedge clk);
    applyStimulus(24'h5AC30F, 24'hF0E1D2);
    runFrameA(1'b0);

    $display("[TB] 256-LED strip");
    for (int i = 0; i < B_LEDS; i++) begin
      memB[i] = 24'($urandom);
      w = wireWord(memB[i]);
      for (int b = 23; b >= 0; b--) qB.push_back(w[b]);
    end
    @(negedge clk);
    busB.start = 1'b1;
    s = cyc;
    @(negedge clk);
    busB.start = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < B_DONE + 50) begin
      @(negedge clk);
      n++;
      if (busB.frame_done) seen = 1'b1;
    end
    checkOutput("B done seen", int'(seen), 1);
    repeat (100) @(negedge clk);
    checkOutput("B done cycle", doneCycB - s, B_DONE);
    checkOutput("B done count", doneCntB, 1);
    checkOutput("B bit count", bitCntB, B_LEDS * 24);
    checkOutput("B bits left", qB.size(), 0);
    checkOutput("B idx changes", idxChangesB, 256);
    checkOutput("B idx final", int'(busB.ledindex), 0);
    checkOutput("B busy final", int'(busB.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ws2811_serializer.md
# ws2811_serializer

Final output stage of the LED chain. Walks `ledindex` through the strip, captures the per-LED colour that the LED controller returns, and serialises it onto the single WS2811 data line with cycle-exact high/low pulse widths. After the last LED it holds the line low for the latch/reset period. It drives `ledindex` directly into the LED controller and accounts for that block's one-cycle registered output.

## Interface
- `NUM_LEDS`, 50: LEDs per frame, range 1..256.
- `BIT_CYCLES`, 63: clk cycles per data bit (1.25 µs at 50 MHz).
- `T0H_CYCLES`, 13: high time of a 0 bit, in cycles.
- `T1H_CYCLES`, 30: high time of a 1 bit, in cycles. Must satisfy 1 ≤ T0H < T1H < BIT_CYCLES.
- `RESET_CYCLES`, 2500: low time after the last bit (50 µs), ≥ 1.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request one frame; sampled only in IDLE.
- `red`, `green`, `blue` in 8 each: colour returned by the LED controller for the current `ledindex`.
- `ledindex` out 8: LED address sent to the LED controller.
- `dout` out 1: WS2811 data line.
- `busy` out 1: high from frame acceptance until `frame_done`.
- `frame_done` out 1: one-cycle pulse at the end of the latch period.

## Operation
- **Reset values:** `dout`=0, `ledindex`=0, `busy`=0, `frame_done`=0, state IDLE, all counters 0.
- **States:**
  - IDLE → PRIME when `start`=1.
  - PRIME lasts 2 cycles, covering the LED controller's combinational-plus-registered path. At the end of PRIME, load the 24-bit shift register from `red`/`green`/`blue` with `ledindex`=0.
  - PRIME → SHIFT.
  - SHIFT → LATCH after bit 23 of LED `NUM_LEDS`-1.
  - LATCH → IDLE after `RESET_CYCLES`.
- **Bit order:** MSB first. Default byte order is R, G, B (R[7] first).
- **Bit encoding:** each bit occupies exactly `BIT_CYCLES` cycles. `dout`=1 for the first T1H_CYCLES cycles if the bit is 1, or the first T0H_CYCLES cycles if it is 0, then `dout`=0 for the rest of the bit period. Bits are contiguous, including across LED boundaries; there are no gap cycles.
- **Prefetch:** on the first cycle of bit 0 of LED n, `ledindex` becomes n+1. On the last LED it becomes 0. On the last cycle of bit 23 of LED n, the shift register reloads from `red`/`green`/`blue`. Loaded data therefore always corresponds to a `ledindex` that has been stable for ≥ 23·`BIT_CYCLES` cycles.
- **Counters:** the bit-cycle counter is sized to hold `BIT_CYCLES`-1, the reset counter to hold `RESET_CYCLES`-1, and the bit counter runs 0..23. The LED counter is 8 bits; `NUM_LEDS`=256 must not overflow its compare.
- **Boundaries:**
  - `start` asserted while `busy`: ignored; no queuing.
  - `start` held high continuously: a new frame begins on the cycle after `frame_done`.
  - `reset` mid-frame: on the next edge every output returns to its reset value and the state goes to IDLE. `dout` goes low even mid-bit.
  - `reset` and `start` asserted together: `reset` wins.
  - Colour inputs changing outside the load cycle: no effect.

## Timing
- Take cycle 0 as the edge where `start`=1 is sampled in IDLE.
- `busy`=1 from cycle 1.
- PRIME occupies cycles 1–2.
- `dout` rises for bit 0 at cycle 3.
- SHIFT spans `NUM_LEDS`·24·`BIT_CYCLES` cycles.
- LATCH holds `dout`=0 for `RESET_CYCLES` cycles.
- `frame_done`=1 and `busy`=0 in the same cycle, `3 + NUM_LEDS·24·BIT_CYCLES + RESET_CYCLES` cycles after cycle 0.
- `frame_done` is exactly one cycle wide.
- `dout` is a direct register output; no combinational path from any input reaches it.

## Configuration
- `WS2811_GRB_ORDER_EN`:
  - When defined, the shift register is loaded G, R, B (G[7] first), for WS2812-style strips.
  - When undefined, the order is R, G, B.
  - Timing, prefetch and state behaviour are identical either way.

## Test plan
Common bench parameters: `NUM_LEDS`=2, `BIT_CYCLES`=10, `T0H`=3, `T1H`=7, `RESET_CYCLES`=20. The bench includes a one-cycle-registered colour model.
- **Single frame:** LED0=(0xFF,0x00,0xAA), LED1=(0x01,0x80,0x00), one-cycle `start` pulse → `dout` rises at cycle 3. The decoded bit stream is FF 00 AA 01 80 00, with high times of 7 or 3 cycles in 10-cycle bits. `frame_done` fires at cycle 3+480+20=503.
- **Prefetch:** `ledindex` is 0 during PRIME, becomes 1 at the cycle-3 bit-0 edge, and becomes 0 at the start of LED1. The LED1 data carries no LED0 residue.
- **Busy handling:** `start` pulsed at cycle 100 while busy → ignored, single frame only. `start` held high → the second frame's `dout` rises 3 cycles after the first `frame_done`.
- **Mid-frame reset:** `reset` at cycle 5, while `dout`=1 → at the next edge `dout`=0, `busy`=0, `ledindex`=0. A `start` afterwards produces a clean frame.
- **Config macro:** with `WS2811_GRB_ORDER_EN` and LED0=(0x12,0x34,0x56) → the first 24 bits decode to 34 12 56.
- **Boundary parameters:** `NUM_LEDS`=256 with `BIT_CYCLES`=4, `T0H`=1, `T1H`=3 → exactly 6144 bits, `ledindex` sequences 0..255 then back to 0, and `frame_done` fires once.
